// File: rtl/button_conditioner_pkg.sv
// rtl/button_conditioner_pkg.sv - shared game-state, direction and button constants
package button_conditioner_pkg;

  // Game state reported back by the master state machine.
  typedef enum logic [1:0] {
    GS_IDLE = 2'b00,
    GS_PLAY = 2'b01,
    GS_OVER = 2'b10,
    GS_BAD  = 2'b11
  } game_state_t;

  // Snake heading; opposite headings differ only in bit 1.
  typedef enum logic [1:0] {
    DIR_UP    = 2'b00,
    DIR_RIGHT = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  // Bit positions of the buttons in the 4-bit button vectors.
  localparam int BTN_UP      = 0;
  localparam int BTN_RIGHT   = 1;
  localparam int BTN_DOWN    = 2;
  localparam int BTN_LEFT    = 3;
  localparam int NUM_BUTTONS = 4;

  // Heading after reset and whenever the game sits in idle.
  localparam logic [1:0] DIR_DEFAULT = DIR_RIGHT;

  // Heading that would make the snake turn back onto itself.
  function automatic logic [1:0] reverse_of(input logic [1:0] dir);
    return dir ^ 2'b10;
  endfunction

  // Lowest-index pressed button wins: up, then right, down, left.
  function automatic logic [1:0] pick_candidate(input logic [3:0] press);
    logic [1:0] cand;
    cand = DIR_LEFT;
    if (press[BTN_DOWN])  cand = DIR_DOWN;
    if (press[BTN_RIGHT]) cand = DIR_RIGHT;
    if (press[BTN_UP])    cand = DIR_UP;
    return cand;
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_bit.sv
// rtl/button_conditioner_debounce_bit.sv - one button: synchroniser, debounce, press pulse; BUTTON_AUTO_REPEAT_EN adds auto-repeat
module debounce_bit #(
  parameter int DEBOUNCE_CYCLES = 500000
`ifdef BUTTON_AUTO_REPEAT_EN
  ,
  parameter int REPEAT_CYCLES   = 5000000
`endif
) (
  input  logic clock,
  input  logic reset_n,
  input  logic raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync_meta;
  logic          sync_q;
  logic [CW-1:0] cnt;
  logic          flip;
  logic          repeat_fire;

  // Level flips once the synchronised input has disagreed for DEBOUNCE_CYCLES cycles.
  assign flip = (sync_q != level) && (cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous pad.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= 1'b0;
      sync_q    <= 1'b0;
    end else begin
      sync_meta <= raw;
      sync_q    <= sync_meta;
    end
  end

  // Disagreement counter: any agreeing cycle restarts the count, so glitches never reach the level.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (sync_q == level || flip) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stable level and its press pulse are registered together, so the pulse marks the first high cycle.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      press <= 1'b0;
    end else begin
      if (flip) begin
        level <= ~level;
      end
      press <= (flip && !level) || repeat_fire;
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_CYCLES);
  localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);

  logic [RW-1:0] rep_cnt;

  // A held button re-fires every REPEAT_CYCLES cycles; never on the cycle it is released.
  assign repeat_fire = level && !flip && (rep_cnt == REP_LAST);

  // Repeat timer runs only while the level is held high and restarts after each repeat.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rep_cnt <= '0;
    end else if (!level || flip || repeat_fire) begin
      rep_cnt <= '0;
    end else begin
      rep_cnt <= rep_cnt + 1'b1;
    end
  end
`else
  assign repeat_fire = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// rtl/button_conditioner.sv - debounced buttons, press pulses and snake heading; BUTTON_AUTO_REPEAT_EN enables auto-repeat
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int REPEAT_CYCLES   = 5000000
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic [3:0] buttons_raw,
  input  logic [1:0] state_in,
  output logic [3:0] buttons_level,
  output logic [3:0] buttons_press,
  output logic [1:0] direction,
  output logic       dir_changed
);

  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
    $error("button_conditioner: DEBOUNCE_CYCLES and REPEAT_CYCLES must be at least 2");
  end

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_button
    debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BUTTON_AUTO_REPEAT_EN
      ,
      .REPEAT_CYCLES  (REPEAT_CYCLES)
`endif
    ) u_debounce (
      .clock  (clock),
      .reset_n(reset_n),
      .raw    (buttons_raw[i]),
      .level  (buttons_level[i]),
      .press  (buttons_press[i])
    );
  end

  logic [1:0] candidate;
  logic       cand_valid;
  logic [1:0] dir_next;
  logic       changed_next;

  assign candidate  = pick_candidate(buttons_press);
  assign cand_valid = |buttons_press;

  // Heading register, one cycle behind the press pulse that steers it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      direction   <= DIR_DEFAULT;
      dir_changed <= 1'b0;
    end else begin
      direction   <= dir_next;
      dir_changed <= changed_next;
    end
  end

  // Next heading: idle forces the default, play accepts non-reversing presses, other states freeze.
  always_comb begin
    dir_next = direction;
    case (state_in)
      GS_IDLE: dir_next = DIR_DEFAULT;
      GS_PLAY: begin
        // A reversal is dropped outright; lower-priority presses in the same cycle are not retried.
        if (cand_valid && candidate != reverse_of(direction)) begin
          dir_next = candidate;
        end
      end
      default: dir_next = direction;
    endcase
  end

  // Change pulse only when the heading actually moves to a different value.
  always_comb begin
    changed_next = 1'b0;
    if (dir_next != direction) begin
      changed_next = 1'b1;
    end
  end

endmodule

// File: doc/button_conditioner.md
Name: button_conditioner

Overview:
- Front-end stage directly upstream of the master game-state machine.
- Synchronises and debounces the four raw push buttons, then produces clean levels and single-cycle press pulses; the press pulses drive the state machine's button input.
- Keeps the snake's current heading in a direction register, with a no-reversal rule, gated by the game state fed back from the state machine.

Parameters:
- DEBOUNCE_CYCLES, 500000: consecutive cycles a synchronised input must differ from the stable level before the level flips; minimum 2.
- REPEAT_CYCLES, 5000000: hold time between auto-repeat pulses; used only with the optional feature.

Ports:
- CLOCK  in  1  system clock; all logic on rising edge.
- RESET_N  in  1  asynchronous, active-low reset.
- BUTTONS_RAW  in  4  raw pads, active-high; bit0 up, bit1 right, bit2 down, bit3 left.
- STATE_IN  in  2  game state: 00 idle, 01 play, 10 over, 11 invalid.
- BUTTONS_LEVEL  out  4  debounced stable levels.
- BUTTONS_PRESS  out  4  one-cycle pulse per debounced rising edge; feeds the state machine's button input.
- DIRECTION  out  2  heading: 00 up, 01 right, 10 down, 11 left.
- DIR_CHANGED  out  1  one-cycle pulse when DIRECTION takes a new value.

Behaviour:
- Reset: all registers clear asynchronously while RESET_N=0 (synchroniser flops, counters, BUTTONS_LEVEL, BUTTONS_PRESS, DIR_CHANGED all 0; DIRECTION=01). Operation resumes on the first rising edge after deassertion. Reset mid-debounce discards partial counts.
- Synchroniser: a two-flop chain per bit; sync[i] is BUTTONS_RAW[i] delayed 2 cycles.
- Debounce, per bit, counter width $clog2(DEBOUNCE_CYCLES):
  - sync == level: counter cleared.
  - sync != level and counter < DEBOUNCE_CYCLES-1: counter increments.
  - sync != level and counter == DEBOUNCE_CYCLES-1: level toggles, counter cleared.
  - Net latency from a stable raw edge to the level change is 2+DEBOUNCE_CYCLES cycles.
  - A glitch shorter than DEBOUNCE_CYCLES synchronised cycles never changes the level.
- Press pulse: BUTTONS_PRESS[i]=1 for exactly the cycle in which BUTTONS_LEVEL[i] first reads 1 (registered together with the level); 0 otherwise. Release produces no pulse.
- Direction candidate: among the bits of BUTTONS_PRESS, the lowest-index set bit wins (up > right > down > left).
- Direction update, registered one cycle after the press pulse:
  - STATE_IN=00: DIRECTION forced to 01 every cycle; presses ignored for direction.
  - STATE_IN=01: a candidate is accepted unless candidate == DIRECTION XOR 2'b10 (a reversal). A reversal is dropped entirely; lower-priority simultaneous presses are not retried. Accepting the current heading leaves DIRECTION unchanged and gives no DIR_CHANGED.
  - STATE_IN=10: DIRECTION frozen.
  - STATE_IN=11: DIRECTION frozen.
- DIR_CHANGED: 1 in the cycle DIRECTION takes a different value, including the force to 01 on entering idle if the heading differed.
- BUTTONS_PRESS is produced regardless of STATE_IN.

Optional Feature:
- Macro: BUTTON_AUTO_REPEAT_EN.
- Defined: while BUTTONS_LEVEL[i] stays 1, a per-button repeat counter issues an extra BUTTONS_PRESS[i] pulse every REPEAT_CYCLES cycles after the initial press. The counter clears when the level falls. Repeat pulses follow the same priority and direction rules as initial presses.
- Undefined: no repeat counters exist; one pulse per press.

Decomposition:
- Shared package holds:
  - game-state constants (IDLE=00, PLAY=01, OVER=10, BAD=11), also used by the state machine;
  - direction constants (UP, RIGHT, DOWN, LEFT) and button bit indices;
  - DIR_DEFAULT=RIGHT.
- Natural sub-module: debounce_bit (synchroniser + counter + level + press pulse, plus optional repeat), instantiated 4 times. Direction logic stays in the top module.

Test Plan (DEBOUNCE_CYCLES=4, REPEAT_CYCLES=10 in simulation):
- Raw bit1 rises and holds -> BUTTONS_LEVEL[1]=1 exactly 6 cycles later, BUTTONS_PRESS=0010 for that one cycle only.
- Raw bit0 pulses high for 3 cycles -> BUTTONS_LEVEL and BUTTONS_PRESS stay 0000.
- STATE_IN=01, DIRECTION=01, press left (bit3) -> DIRECTION stays 01, DIR_CHANGED=0. Then press down -> DIRECTION=10 one cycle after the pulse, DIR_CHANGED pulses once.
- STATE_IN=01, DIRECTION=10, bits 0 and 3 pressed simultaneously -> candidate up is a reversal and is dropped; DIRECTION remains 10.
- DIRECTION=00, STATE_IN switches to 00 -> DIRECTION=01 next cycle with DIR_CHANGED=1. Assert RESET_N=0 mid-debounce -> all outputs 0 immediately, DIRECTION=01.
- BUTTON_AUTO_REPEAT_EN defined, hold bit2 for 40 cycles -> press pulses at first-level cycle, then +10, +20, +30. Macro undefined -> only the first pulse.
